event_unit_periph_initiator: RTL

// - Initiator (master) side of the XBAR_PERIPH_BUS req/gnt/r_valid protocol; the counterpart of the event unit slave ports.
// - Queues commands (add/wen/wdata/be/id) from a local client: DMA-side event forwarder, test sequencer or inter-cluster notifier.
// - Issues commands on the bus one at a time, returns responses in order with an error flag.
// - Sits between a client valid/ready interface and one XBAR_PERIPH_BUS master plug.

---
 rtl/event_unit_pkg.sv | 23 ++
 rtl/event_unit_periph_initiator_fifo_v3.sv | 60 ++++++
 rtl/event_unit_periph_initiator.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/event_unit_pkg.sv
// Shared types for the event unit peripheral-bus initiator: the command
// record queued from the client and the response record returned to it.
package event_unit_pkg;

   localparam int unsigned EU_BUS_DW   = 32;
   localparam int unsigned EU_BE_W     = EU_BUS_DW / 8;
   localparam int unsigned EU_ID_WIDTH = 5;

   typedef struct packed {
      logic [EU_BUS_DW-1:0]   add;
      logic                   wen;
      logic [EU_BUS_DW-1:0]   wdata;
      logic [EU_BE_W-1:0]     be;
      logic [EU_ID_WIDTH-1:0] id;
   } eu_cmd_t;

   typedef struct packed {
      logic [EU_BUS_DW-1:0]   rdata;
      logic [EU_ID_WIDTH-1:0] id;
      logic                   err;
   } eu_rsp_t;

endpackage

// File: rtl/event_unit_periph_initiator_fifo_v3.sv
// Small synchronous FIFO (common_cells fifo_v3 style) with a registered
// storage array; the head entry is read straight out of the array.
// DEPTH must be a power of two so the pointers wrap on their own.
module fifo_v3 #(
   parameter int unsigned DEPTH = 4,
   parameter type         dtype = logic [31:0]
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic push_i,
   input  dtype data_i,
   input  logic pop_i,
   output dtype data_o,
   output logic full_o,
   output logic empty_o
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

   logic [AW-1:0] rdPtr_q;
   logic [AW-1:0] wrPtr_q;
   logic [AW:0]   count_q;
   dtype          mem_q [DEPTH];
   logic          doPush;
   logic          doPop;

   assign full_o  = (count_q == FULL_COUNT);
   assign empty_o = (count_q == '0);
   assign doPop   = pop_i && !empty_o;
   assign doPush  = push_i && (!full_o || doPop);
   assign data_o  = mem_q[rdPtr_q];

   // Storage, pointers and occupancy; a push into a full FIFO only lands
   // when the head is popped in the same cycle.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rdPtr_q <= '0;
         wrPtr_q <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         if (doPush) begin
            mem_q[wrPtr_q] <= data_i;
            wrPtr_q        <= wrPtr_q + AW'(1);
         end
         if (doPop) begin
            rdPtr_q <= rdPtr_q + AW'(1);
         end
         if (doPush && !doPop) begin
            count_q <= count_q + (AW+1)'(1);
         end else if (doPop && !doPush) begin
            count_q <= count_q - (AW+1)'(1);
         end
      end
   end

endmodule

// File: rtl/event_unit_periph_initiator.sv
// Master side of the XBAR_PERIPH_BUS req/gnt/r_valid protocol. Client
// commands are queued, issued one at a time, and their responses are
// returned in order. A response slot is reserved before a command is
// issued, so a stalled client stalls the bus side instead of overflowing.
module event_unit_periph_initiator
   import event_unit_pkg::*;
#(
   parameter int unsigned CMD_DEPTH = 4,
   parameter int unsigned ID_WIDTH  = EU_ID_WIDTH,
   parameter int unsigned TIMEOUT   = 64
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                cmd_valid_i,
   output logic                cmd_ready_o,
   input  logic [31:0]         cmd_add_i,
   input  logic                cmd_wen_i,
   input  logic [31:0]         cmd_wdata_i,
   input  logic [3:0]          cmd_be_i,
   input  logic [ID_WIDTH-1:0] cmd_id_i,
   output logic                rsp_valid_o,
   input  logic                rsp_ready_i,
   output logic [31:0]         rsp_rdata_o,
   output logic [ID_WIDTH-1:0] rsp_id_o,
   output logic                rsp_err_o,
   output logic                req_o,
   output logic [31:0]         add_o,
   output logic                wen_o,
   output logic [31:0]         wdata_o,
   output logic [3:0]          be_o,
   output logic [ID_WIDTH-1:0] id_o,
   input  logic                gnt_i,
   input  logic                r_valid_i,
   input  logic [31:0]         r_rdata_i,
   input  logic                r_opc_i,
   input  logic [ID_WIDTH-1:0] r_id_i
);

   localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] REQ    = 2'd1;
   localparam logic [1:0] WAIT_R = 2'd2;

   logic [1:0]          state_q, state_d;
   logic [CNT_W-1:0]    timer_q, timer_d;
   logic [ID_WIDTH-1:0] id_q, id_d;
   logic                wen_q, wen_d;

   eu_cmd_t cmdIn, cmdHead;
   eu_rsp_t rspIn, rspHead;
   logic    cmdFull, cmdEmpty, cmdPush, cmdPop;
   logic    rspFull, rspEmpty, rspPush, rspPop;
   logic    unusedRid;

   // The response id always comes from the latched command id.
   assign unusedRid = ^r_id_i;

   assign cmdIn = '{add:   cmd_add_i,
                    wen:   cmd_wen_i,
                    wdata: cmd_wdata_i,
                    be:    cmd_be_i,
                    id:    EU_ID_WIDTH'(cmd_id_i)};

   assign cmd_ready_o = !cmdFull;
   assign cmdPush     = cmd_valid_i && !cmdFull;

   assign rsp_valid_o = !rspEmpty;
   assign rspPop      = rsp_valid_o && rsp_ready_i;
   assign rsp_rdata_o = rspHead.rdata;
   assign rsp_id_o    = ID_WIDTH'(rspHead.id);
   assign rsp_err_o   = rspHead.err;

   // Bus fields come only from the state register and the FIFO head, so
   // gnt_i never reaches req_o combinationally and fields stay put until grant.
   assign req_o   = (state_q == REQ);
   assign add_o   = req_o ? cmdHead.add   : '0;
   assign wen_o   = req_o ? cmdHead.wen   : 1'b1;
   assign wdata_o = req_o ? cmdHead.wdata : '0;
   assign be_o    = req_o ? cmdHead.be    : '0;
   assign id_o    = req_o ? ID_WIDTH'(cmdHead.id) : '0;

   fifo_v3 #(
      .DEPTH (CMD_DEPTH),
      .dtype (eu_cmd_t)
   ) i_cmd_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (cmdPush),
      .data_i  (cmdIn),
      .pop_i   (cmdPop),
      .data_o  (cmdHead),
      .full_o  (cmdFull),
      .empty_o (cmdEmpty)
   );

   fifo_v3 #(
      .DEPTH (2),
      .dtype (eu_rsp_t)
   ) i_rsp_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (rspPush),
      .data_i  (rspIn),
      .pop_i   (rspPop),
      .data_o  (rspHead),
      .full_o  (rspFull),
      .empty_o (rspEmpty)
   );

   // Issue FSM: one outstanding transaction, completed by r_valid_i or by
   // the timeout, and chained straight into the next request when possible.
   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      id_d    = id_q;
      wen_d   = wen_q;
      cmdPop  = 1'b0;
      rspPush = 1'b0;
      rspIn   = '0;
      unique case (state_q)
         IDLE: begin
            if (!cmdEmpty && !rspFull) begin
               state_d = REQ;
            end
         end
         REQ: begin
            if (gnt_i) begin
               cmdPop  = 1'b1;
               id_d    = ID_WIDTH'(cmdHead.id);
               wen_d   = cmdHead.wen;
               timer_d = '0;
               state_d = WAIT_R;
            end
         end
         WAIT_R: begin
            if (r_valid_i || (timer_q == TIMEOUT_LAST)) begin
               rspPush  = 1'b1;
               rspIn.id = EU_ID_WIDTH'(id_q);
               if (r_valid_i) begin
                  rspIn.rdata = wen_q ? r_rdata_i : '0;
                  rspIn.err   = r_opc_i;
               end else begin
                  rspIn.rdata = '0;
                  rspIn.err   = 1'b1;
               end
               state_d = (!cmdEmpty && (rspEmpty || rspPop)) ? REQ : IDLE;
            end else begin
               timer_d = timer_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // FSM state, timeout counter and the id/wen latched at grant.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         timer_q <= '0;
         id_q    <= '0;
         wen_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         id_q    <= id_d;
         wen_q   <= wen_d;
      end
   end

endmodule
